scpad_tile_addr_gen: RTL and testbench
======================================

// Module: scpad_tile_addr_gen
// PURPOSE
// - Turns one tile request (scratchpad id, base slot, rows x cols, row/transpose mode) into a burst of
//   per-beat bank access vectors (slot_mask, shift_mask, valid_mask) for the SRAM controller / crossbar.
// - Generalises the scratchpad addressing to NUM_SCPADS>1 and adds a diagonal-skew layout, so tiles can be
//   read row-major or transposed (column-major) conflict-free: element (r,c) lives in bank (c+r)%NUM_COLS,
//   slot base+r. Sits between the frontend arbiter and the SRAM controller.
// PARAMETERS
// - NUM_SCPADS        2        scratchpad instances; SCPAD_ID_WIDTH = max(1,$clog2(NUM_SCPADS))
// - NUM_COLS          32       banks/lanes per row, power of 2; COL_IDX_WIDTH = $clog2(NUM_COLS)
// - NUM_ROWS          16384    slots per bank, power of 2; ROW_IDX_WIDTH = $clog2(NUM_ROWS)
// - MAX_TILE_SIZE     32       max tile dim, <= NUM_COLS; MAX_DIM_WIDTH = $clog2(MAX_TILE_SIZE)
// PORTS
// - CLK            in   1               clock
// - nRST           in   1               reset, synchronous, active-low
// - req_valid      in   1               tile request valid
// - req_ready      out  1               tile request accepted when valid&ready
// - req_scpad_id   in   SCPAD_ID_WIDTH  target scratchpad
// - req_base_row   in   ROW_IDX_WIDTH   slot of tile row 0
// - req_rows_m1    in   MAX_DIM_WIDTH   tile rows minus 1
// - req_cols_m1    in   MAX_DIM_WIDTH   tile cols minus 1
// - req_transpose  in   1               0: one beat per tile row; 1: one beat per tile column
// - flush          in   1               abandon current tile
// - beat_valid     out  1               beat vectors valid
// - beat_ready     in   1               downstream accepts beat
// - beat_scpad_id  out  SCPAD_ID_WIDTH  latched req_scpad_id
// - beat_slot      out  slot_mask       per-bank slot index
// - beat_shift     out  shift_mask      per-bank destination lane
// - beat_mask      out  valid_mask      per-bank enable
// - beat_idx       out  MAX_DIM_WIDTH   beat number within tile (k)
// - beat_last      out  1               final beat of tile
// - busy           out  1               state==BURST
// BEHAVIOUR
// - FSM IDLE/BURST. Reset: state=IDLE, k=0, all latched fields 0; outputs beat_valid=0, busy=0, beat_last=0,
//   beat_* vectors 0 (forced 0 whenever beat_valid=0).
// - req_ready = (state==IDLE) | (beat_valid & beat_ready & beat_last & ~flush). Request is latched on
//   handshake; beat 0 is presented the next cycle (latency 1); back-to-back tiles have no bubble.
// - BURST: beat_valid=1; beat vectors are combinational from registered state. On beat_ready, k++.
//   On handshake of beat_last: go IDLE, or reload k=0 with new request if one handshakes same cycle.
// - Beat count N = transpose ? cols : rows; beat_last = (k == N-1). Single-beat tile (N=1): beat_last on beat 0.
// - Per bank b, let d = (b - k) mod NUM_COLS (COL_IDX_WIDTH-bit wrap subtraction):
//   row mode:       slot[b]=base+k;  shift[b]=d;  mask[b] = (d <= cols_m1)
//   transpose mode: slot[b]=base+d;  shift[b]=d;  mask[b] = (d <= rows_m1)
//   Disabled banks output slot=0, shift=0. Slot arithmetic wraps modulo NUM_ROWS (ROW_IDX_WIDTH truncation).
// - beat_valid held with stable vectors until beat_ready (no retraction, no change).
// - flush (any state): next cycle state=IDLE, k=0, beat_valid=0; a req handshake is not possible in
//   the flush cycle (req_ready forced 0 while flush=1). flush wins over beat_ready.
// - nRST low mid-burst: next edge returns to reset state; partial tile is discarded, no beats emitted.
// STRUCTURE
// - Shared package (scratchpad types): NUM_SCPADS, NUM_COLS, NUM_ROWS, MAX_TILE_SIZE and derived widths;
//   typedefs scpad_data, valid_mask, shift_mask, slot_mask; new typedef tile_req_t
//   {scpad_id, base_row, rows_m1, cols_m1, transpose}; enum addr_gen_state_t {IDLE, BURST}.
// - One sub-module: scpad_skew_lane_calc (combinational, per-bank d/slot/shift/mask from k, mode, tile).
// TESTING
// - Reset: hold nRST=0 3 cycles with req_valid=1 -> req_ready=0, beat_valid=0, vectors 0; after release req_ready=1.
// - Row 4x32 base=100: 4 beats; beat k=2 -> all slot=102, shift[b]=(b-2)%32, mask=all 1s, last on k=3.
// - Transpose 8x3 base=16380: 3 beats; beat k=1 -> mask bits b=1..8 set, slot[5]=16384 wraps to 0, shift[5]=4.
// - Back-to-back: second req valid during last-beat handshake -> accepted same cycle, its beat 0 next cycle.
// - Backpressure: beat_ready=0 for 5 cycles at k=1 -> vectors and beat_idx unchanged; busy stays 1.
// - flush at k=1 of 1x32 transpose (32 beats) -> beat_valid=0 next cycle, req_ready=1; new 1x1 row req yields
//   one beat, mask=1 at bank 0 only, beat_last=1.

Source files
------------

// File: rtl/scpad_tile_addr_gen_pkg.sv
// rtl/scpad_tile_addr_gen_pkg.sv - shared scratchpad geometry, vector types and tile request types
package scpad_tile_addr_gen_pkg;

    localparam int NUM_SCPADS     = 2;
    localparam int NUM_COLS       = 32;
    localparam int NUM_ROWS       = 16384;
    localparam int MAX_TILE_SIZE  = 32;

    localparam int SCPAD_ID_WIDTH = (NUM_SCPADS > 1) ? $clog2(NUM_SCPADS) : 1;
    localparam int COL_IDX_WIDTH  = $clog2(NUM_COLS);
    localparam int ROW_IDX_WIDTH  = $clog2(NUM_ROWS);
    localparam int MAX_DIM_WIDTH  = $clog2(MAX_TILE_SIZE);

    typedef logic [NUM_COLS-1:0]                     valid_mask;
    typedef logic [NUM_COLS-1:0][COL_IDX_WIDTH-1:0]  shift_mask;
    typedef logic [NUM_COLS-1:0][ROW_IDX_WIDTH-1:0]  slot_mask;
    typedef logic [NUM_COLS-1:0][31:0]               scpad_data;

    typedef struct packed {
        logic [SCPAD_ID_WIDTH-1:0] scpad_id;
        logic [ROW_IDX_WIDTH-1:0]  base_row;
        logic [MAX_DIM_WIDTH-1:0]  rows_m1;
        logic [MAX_DIM_WIDTH-1:0]  cols_m1;
        logic                      transpose;
    } tile_req_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } addr_gen_state_t;

    // Index of the final beat: one beat per row, or per column when transposed.
    function automatic logic [MAX_DIM_WIDTH-1:0] tile_last_idx(input tile_req_t t);
        return t.transpose ? t.cols_m1 : t.rows_m1;
    endfunction

endpackage

// File: rtl/scpad_skew_lane_calc.sv
// rtl/scpad_skew_lane_calc.sv - per-bank slot/shift/enable for one beat of a diagonally skewed tile
// Ports:
//   en         in   force all outputs to 0 when low
//   k          in   beat number within the tile
//   transpose  in   0: beat walks a tile row, 1: beat walks a tile column
//   base_row   in   slot of tile row 0
//   rows_m1    in   tile rows minus 1
//   cols_m1    in   tile cols minus 1
//   slot       out  per-bank slot index
//   shift      out  per-bank destination lane
//   mask       out  per-bank enable
module scpad_skew_lane_calc
    import scpad_tile_addr_gen_pkg::*;
(
    input  logic                     en,
    input  logic [MAX_DIM_WIDTH-1:0] k,
    input  logic                     transpose,
    input  logic [ROW_IDX_WIDTH-1:0] base_row,
    input  logic [MAX_DIM_WIDTH-1:0] rows_m1,
    input  logic [MAX_DIM_WIDTH-1:0] cols_m1,
    output slot_mask                 slot,
    output shift_mask                shift,
    output valid_mask                mask
);

    logic [COL_IDX_WIDTH-1:0] d;
    logic [COL_IDX_WIDTH-1:0] lim;

    // Element (r,c) sits in bank (c+r) mod NUM_COLS. For beat k, bank b therefore
    // holds the element whose "other" coordinate is d = (b-k) mod NUM_COLS: the
    // column in row mode, the row in transpose mode. d is also its output lane.
    always_comb begin
        slot  = '0;
        shift = '0;
        mask  = '0;
        d     = '0;
        lim   = COL_IDX_WIDTH'(transpose ? rows_m1 : cols_m1);
        for (int b = 0; b < NUM_COLS; b++) begin
            d = COL_IDX_WIDTH'(b) - COL_IDX_WIDTH'(k);
            if (en && (d <= lim)) begin
                mask[b]  = 1'b1;
                shift[b] = d;
                // Slot sum truncates to ROW_IDX_WIDTH, wrapping around the bank depth.
                slot[b]  = transpose ? (base_row + ROW_IDX_WIDTH'(d))
                                     : (base_row + ROW_IDX_WIDTH'(k));
            end
        end
    end

endmodule

// File: rtl/scpad_tile_addr_gen.sv
// rtl/scpad_tile_addr_gen.sv - tile request to per-beat bank access vector burst generator
// Ports:
//   CLK, nRST                clock, synchronous active-low reset
//   req_valid/req_ready      tile request handshake
//   req_scpad_id..transpose  tile request fields
//   flush                    abandon current tile
//   beat_valid/beat_ready    beat handshake
//   beat_scpad_id            latched scratchpad id
//   beat_slot/shift/mask     per-bank access vectors
//   beat_idx, beat_last      beat number and final-beat flag
//   busy                     burst in progress
module scpad_tile_addr_gen
    import scpad_tile_addr_gen_pkg::*;
(
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SCPAD_ID_WIDTH-1:0] req_scpad_id,
    input  logic [ROW_IDX_WIDTH-1:0]  req_base_row,
    input  logic [MAX_DIM_WIDTH-1:0]  req_rows_m1,
    input  logic [MAX_DIM_WIDTH-1:0]  req_cols_m1,
    input  logic                      req_transpose,
    input  logic                      flush,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [SCPAD_ID_WIDTH-1:0] beat_scpad_id,
    output slot_mask                  beat_slot,
    output shift_mask                 beat_shift,
    output valid_mask                 beat_mask,
    output logic [MAX_DIM_WIDTH-1:0]  beat_idx,
    output logic                      beat_last,
    output logic                      busy
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_BURST = BURST;

    logic [0:0]               state_q;
    logic [MAX_DIM_WIDTH-1:0] k_q;
    tile_req_t                tile_q;

    logic in_burst;
    logic at_last;
    logic beat_fire;
    logic req_fire;

    assign in_burst  = (state_q == ST_BURST);
    assign at_last   = (k_q == tile_last_idx(tile_q));
    assign beat_fire = in_burst & beat_ready;

    // Accepting on the last-beat handshake lets tiles run back to back without a
    // bubble. Gated by reset so nothing is accepted while reset is held.
    assign req_ready = nRST & ~flush & (~in_burst | (beat_fire & at_last));
    assign req_fire  = req_valid & req_ready;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            tile_q  <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else if (req_fire) begin
            state_q <= ST_BURST;
            k_q     <= '0;
            tile_q  <= '{scpad_id:  req_scpad_id,
                         base_row:  req_base_row,
                         rows_m1:   req_rows_m1,
                         cols_m1:   req_cols_m1,
                         transpose: req_transpose};
        end else if (beat_fire) begin
            if (at_last) begin
                state_q <= ST_IDLE;
                k_q     <= '0;
            end else begin
                k_q     <= k_q + 1'b1;
            end
        end
    end

    scpad_skew_lane_calc u_lane_calc (
        .en        (in_burst),
        .k         (k_q),
        .transpose (tile_q.transpose),
        .base_row  (tile_q.base_row),
        .rows_m1   (tile_q.rows_m1),
        .cols_m1   (tile_q.cols_m1),
        .slot      (beat_slot),
        .shift     (beat_shift),
        .mask      (beat_mask)
    );

    assign busy          = in_burst;
    assign beat_valid    = in_burst;
    assign beat_scpad_id = in_burst ? tile_q.scpad_id : '0;
    assign beat_idx      = in_burst ? k_q : '0;
    assign beat_last     = in_burst & at_last;

endmodule

// File: tb/tb_scpad_tile_addr_gen.sv
// tb/tb_scpad_tile_addr_gen.sv - self-checking bench for scpad_tile_addr_gen
module tb_scpad_tile_addr_gen;
    import scpad_tile_addr_gen_pkg::*;

    logic                      CLK = 1'b0;
    logic                      nRST;
    logic                      req_valid;
    logic                      req_ready;
    logic [SCPAD_ID_WIDTH-1:0] req_scpad_id;
    logic [ROW_IDX_WIDTH-1:0]  req_base_row;
    logic [MAX_DIM_WIDTH-1:0]  req_rows_m1;
    logic [MAX_DIM_WIDTH-1:0]  req_cols_m1;
    logic                      req_transpose;
    logic                      flush;
    logic                      beat_valid;
    logic                      beat_ready;
    logic [SCPAD_ID_WIDTH-1:0] beat_scpad_id;
    slot_mask                  beat_slot;
    shift_mask                 beat_shift;
    valid_mask                 beat_mask;
    logic [MAX_DIM_WIDTH-1:0]  beat_idx;
    logic                      beat_last;
    logic                      busy;

    scpad_tile_addr_gen dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_scpad_id  (req_scpad_id),
        .req_base_row  (req_base_row),
        .req_rows_m1   (req_rows_m1),
        .req_cols_m1   (req_cols_m1),
        .req_transpose (req_transpose),
        .flush         (flush),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .beat_scpad_id (beat_scpad_id),
        .beat_slot     (beat_slot),
        .beat_shift    (beat_shift),
        .beat_mask     (beat_mask),
        .beat_idx      (beat_idx),
        .beat_last     (beat_last),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    valid_mask cap_mask[32];
    slot_mask  cap_slot[32];
    shift_mask cap_shift[32];

    typedef struct {
        logic        tr;
        int          rows_m1;
        int          cols_m1;
        int          base;
        int          pk;
        int          pb;
        int          nb;
        logic [31:0] m;
        int          s;
        int          sh;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference: place every tile element touched by beat k into its bank.
    task automatic model_beat(input tile_req_t t, input int k,
                              output valid_mask m, output slot_mask s, output shift_mask sh);
        int b;
        m = '0; s = '0; sh = '0;
        if (!t.transpose) begin
            for (int c = 0; c <= int'(t.cols_m1); c++) begin
                b = (c + k) % NUM_COLS;
                m[b]  = 1'b1;
                s[b]  = ROW_IDX_WIDTH'((int'(t.base_row) + k) % NUM_ROWS);
                sh[b] = COL_IDX_WIDTH'(c);
            end
        end else begin
            for (int r = 0; r <= int'(t.rows_m1); r++) begin
                b = (k + r) % NUM_COLS;
                m[b]  = 1'b1;
                s[b]  = ROW_IDX_WIDTH'((int'(t.base_row) + r) % NUM_ROWS);
                sh[b] = COL_IDX_WIDTH'(r);
            end
        end
    endtask

    task automatic check_beat(input tile_req_t t, input int k);
        valid_mask m; slot_mask s; shift_mask sh;
        int n;
        model_beat(t, k, m, s, sh);
        n = t.transpose ? int'(t.cols_m1) + 1 : int'(t.rows_m1) + 1;
        check("beat_valid", 512'(beat_valid), 512'(1));
        check("beat_mask", 512'(beat_mask), 512'(m));
        check("beat_slot", 512'(beat_slot), 512'(s));
        check("beat_shift", 512'(beat_shift), 512'(sh));
        check("beat_idx", 512'(beat_idx), 512'(k));
        check("beat_last", 512'(beat_last), 512'(k == n - 1));
        check("beat_scpad_id", 512'(beat_scpad_id), 512'(t.scpad_id));
        check("busy", 512'(busy), 512'(1));
    endtask

    task automatic drive(input tile_req_t t);
        req_scpad_id  = t.scpad_id;
        req_base_row  = t.base_row;
        req_rows_m1   = t.rows_m1;
        req_cols_m1   = t.cols_m1;
        req_transpose = t.transpose;
    endtask

    function automatic tile_req_t mk(input int id, input int base, input int rm1,
                                     input int cm1, input logic tr);
        tile_req_t t;
        t.scpad_id  = SCPAD_ID_WIDTH'(id);
        t.base_row  = ROW_IDX_WIDTH'(base);
        t.rows_m1   = MAX_DIM_WIDTH'(rm1);
        t.cols_m1   = MAX_DIM_WIDTH'(cm1);
        t.transpose = tr;
        return t;
    endfunction

    task automatic send_req(input tile_req_t t);
        int guard = 0;
        @(negedge CLK);
        drive(t);
        req_valid  = 1'b1;
        beat_ready = 1'b0;
        #1;
        while (!req_ready && guard < 50) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", 512'(0), 512'(1));
    endtask

    // Collect beats of tile t; the request handshake is on the edge just before entry.
    task automatic run_beats(input tile_req_t t, input bit rnd_ready, output int nbeats);
        int  k = 0;
        int  guard = 0;
        bit  done = 0;
        bit  first = 1;
        while (!done && guard < 400) begin
            @(negedge CLK);
            req_valid  = 1'b0;
            beat_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            guard++;
            if (first) begin
                check("beat0_latency", 512'(beat_valid), 512'(1));
                first = 0;
            end
            if (beat_valid) begin
                if (k < 32) check_beat(t, k);
                if (beat_ready) begin
                    if (k < 32) begin
                        cap_mask[k]  = beat_mask;
                        cap_slot[k]  = beat_slot;
                        cap_shift[k] = beat_shift;
                    end
                    k++;
                    if (beat_last || k > 32) done = 1;
                end
            end
        end
        if (!done) check("beat_timeout", 512'(0), 512'(1));
        nbeats = k;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tile_req_t t, t2;
        int nb;

        vt[0] = '{1'b0,  3, 31,   100,  2,  0,  4, 32'hFFFF_FFFF,   102, 30};
        vt[1] = '{1'b1,  7,  2, 16380,  1,  5,  3, 32'h0000_01FE,     0,  4};
        vt[2] = '{1'b0,  2,  4,     0,  1,  3,  3, 32'h0000_003E,     1,  2};
        vt[3] = '{1'b1,  1,  3,    50,  3,  0,  4, 32'h0000_0018,     0,  0};
        vt[4] = '{1'b0,  0, 31, 16383,  0, 31,  1, 32'hFFFF_FFFF, 16383, 31};
        vt[5] = '{1'b0, 31,  1, 16370, 31,  0, 32, 32'h8000_0001,    17,  1};
        vt[6] = '{1'b1, 31,  0,     5,  0,  7,  1, 32'hFFFF_FFFF,    12,  7};

        // Reset held with a pending request
        nRST = 1'b0; flush = 1'b0; beat_ready = 1'b0; req_valid = 1'b1;
        drive(mk(1, 3, 2, 2, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check("rst_req_ready", 512'(req_ready), 512'(0));
            check("rst_beat_valid", 512'(beat_valid), 512'(0));
            check("rst_beat_mask", 512'(beat_mask), 512'(0));
            check("rst_beat_slot", 512'(beat_slot), 512'(0));
            check("rst_beat_shift", 512'(beat_shift), 512'(0));
            check("rst_busy", 512'(busy), 512'(0));
            check("rst_beat_last", 512'(beat_last), 512'(0));
        end
        req_valid = 1'b0;
        nRST = 1'b1;
        #1;
        check("post_rst_req_ready", 512'(req_ready), 512'(1));

        // Table-driven tiles
        for (int i = 0; i < 7; i++) begin
            t = mk(i % 2, vt[i].base, vt[i].rows_m1, vt[i].cols_m1, vt[i].tr);
            send_req(t);
            run_beats(t, 1'b0, nb);
            check("tbl_nbeats", 512'(nb), 512'(vt[i].nb));
            check("tbl_mask", 512'(cap_mask[vt[i].pk]), 512'(vt[i].m));
            check("tbl_slot", 512'(cap_slot[vt[i].pk][vt[i].pb]), 512'(vt[i].s));
            check("tbl_shift", 512'(cap_shift[vt[i].pk][vt[i].pb]), 512'(vt[i].sh));
        end

        // Back-to-back: next request offered during last-beat handshake
        t  = mk(0, 7, 1, 3, 1'b0);
        t2 = mk(1, 300, 2, 5, 1'b1);
        send_req(t);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            req_valid  = 1'b0;
            beat_ready = 1'b1;
            if (k == 1) begin
                drive(t2);
                req_valid = 1'b1;
            end
            #1;
            check_beat(t, k);
            if (k == 1) check("b2b_req_ready", 512'(req_ready), 512'(1));
        end
        run_beats(t2, 1'b0, nb);
        check("b2b_nbeats", 512'(nb), 512'(6));

        // Backpressure at k=1
        t = mk(0, 200, 3, 31, 1'b0);
        send_req(t);
        @(negedge CLK);
        req_valid = 1'b0; beat_ready = 1'b1;
        #1;
        check_beat(t, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            beat_ready = 1'b0;
            #1;
            check_beat(t, 1);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK);
            beat_ready = 1'b1;
            #1;
            check_beat(t, k);
        end
        @(negedge CLK);
        #1;
        check("bp_done_valid", 512'(beat_valid), 512'(0));
        check("bp_done_req_ready", 512'(req_ready), 512'(1));

        // Flush at k=1 of a 32-beat transposed tile, then a 1x1 tile
        t  = mk(1, 40, 0, 31, 1'b1);
        t2 = mk(0, 9, 0, 0, 1'b0);
        send_req(t);
        @(negedge CLK);
        req_valid = 1'b0; beat_ready = 1'b1;
        #1;
        check_beat(t, 0);
        @(negedge CLK);
        flush = 1'b1; beat_ready = 1'b1;
        drive(t2);
        req_valid = 1'b1;
        #1;
        check_beat(t, 1);
        check("flush_req_ready", 512'(req_ready), 512'(0));
        @(negedge CLK);
        flush = 1'b0;
        #1;
        check("flush_beat_valid", 512'(beat_valid), 512'(0));
        check("flush_busy", 512'(busy), 512'(0));
        check("flush_beat_mask", 512'(beat_mask), 512'(0));
        check("flush_req_ready_after", 512'(req_ready), 512'(1));
        run_beats(t2, 1'b0, nb);
        check("one_nbeats", 512'(nb), 512'(1));
        check("one_mask", 512'(cap_mask[0]), 512'(32'h1));
        check("one_slot0", 512'(cap_slot[0][0]), 512'(9));

        // Reset mid-burst discards the tile
        t = mk(0, 1000, 7, 31, 1'b0);
        send_req(t);
        @(negedge CLK);
        req_valid = 1'b0; beat_ready = 1'b1;
        #1;
        check_beat(t, 0);
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        #1;
        check("midrst_valid", 512'(beat_valid), 512'(0));
        check("midrst_busy", 512'(busy), 512'(0));
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check("midrst_no_beats", 512'(beat_valid), 512'(0));
        end

        // Randomized tiles with random backpressure
        for (int i = 0; i < 40; i++) begin
            t = mk($urandom_range(0, NUM_SCPADS - 1), $urandom_range(0, NUM_ROWS - 1),
                   $urandom_range(0, MAX_TILE_SIZE - 1), $urandom_range(0, MAX_TILE_SIZE - 1),
                   1'($urandom_range(0, 1)));
            send_req(t);
            run_beats(t, 1'b1, nb);
            check("rnd_nbeats", 512'(nb),
                  512'(t.transpose ? int'(t.cols_m1) + 1 : int'(t.rows_m1) + 1));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
